vga_text_render: RTL and testbench
==================================

# vga_text_render

Character-mode pixel generator that drives the VGA port in the text display path. It generates 640×480@60 timing and walks the screen in 12×16 character cells. Per pixel it fetches a character code from the text buffer and issues a glyph-row address to the font ROM. It then selects the pixel bit from the 12-bit row returned by the ROM and outputs colour plus syncs, all aligned. It is the direct consumer of the font ROM (12-bit address, 12-bit data, 1-cycle synchronous read on `clk`).

## Interface
- `FG_COLOR`, 12'hFFF, foreground RGB 4:4:4.
- `BG_COLOR`, 12'h000, background RGB 4:4:4.
- `BLINK_FRAMES`, 32, frames per cursor blink half-period (≥1).
- `clk`  in  1  pixel clock, 25 MHz; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `text_addr`  out  11  text buffer address {row[4:0], col[5:0]}.
- `char_code`  in  8  text buffer data, valid 1 cycle after `text_addr`.
- `font_addr`  out  12  font ROM address {char_code[7:0], line[3:0]}.
- `font_row`  in  12  font ROM data, valid 1 cycle after `font_addr`; bit 11 = leftmost pixel.
- `cursor_col`  in  6  cursor column, 0..52.
- `cursor_row`  in  5  cursor row, 0..29.
- `cursor_en`  in  1  cursor enable.
- `vga_hs`, `vga_vs`  out  1 each  syncs, active low.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour.
- `vga_de`  out  1  visible-pixel flag.

## Operation
- Horizontal: `hcnt` 0..799, with visible 0..639, front porch 640..655, sync 656..751 and back porch 752..799.
- Vertical: `vcnt` 0..524 advances when `hcnt` wraps, with visible 0..479, front porch 480..489, sync 490..491 and back porch 492..524.
- Cell counters run alongside the raster counters, so no divider is used:
  - `px` 0..11 and `col` 0..63 clear at `hcnt`=0; `px` wraps to 0 and increments `col`.
  - `line` 0..15 and `row` clear at `vcnt`=0 and advance on each `hcnt` wrap.
- 53 text columns cover pixels 0..635. Columns 636..639 form the right margin, which always outputs `BG_COLOR`.
- 30 text rows cover lines 0..479.
- `text_addr` = {row, col}, driven every cycle; stride 64, columns 53..63 unused.
- `font_addr` = {`char_code`, line delayed 1}.
- Pixel bit = `font_row[11 - px]`, using `px` delayed 2.
- Cursor cell: `cursor_en`=1, (col,row) equals (`cursor_col`,`cursor_row`), and blink phase = 1.
  - In a cursor cell the pixel bit is inverted.
  - The blink counter counts frames at (`hcnt`,`vcnt`)=(0,0); phase toggles every `BLINK_FRAMES` frames.
- Colour output is `FG_COLOR` if the final bit is 1, else `BG_COLOR`. Outputs are 0 when not visible.
- Cursor inputs are sampled at stage 0; changes take effect at the next pixel.

## Timing
- Pipeline, with stage 0 at the cycle where the counters hold a given (`hcnt`,`vcnt`):
  - Stage 0: drive `text_addr`.
  - Stage 1: drive `font_addr`.
  - Stage 2: bit select.
  - Stage 3: registered `vga_*` outputs.
- Total latency from counter value to pins is 3 cycles. `vga_hs`, `vga_vs` and `vga_de` are delayed by the same 3 cycles.
- Reset values:
  - Counters, blink counter and phase: 0.
  - `vga_hs`=1, `vga_vs`=1, `vga_de`=0, RGB=0.
  - `text_addr`=0, `font_addr`=0.
  - All pipeline registers are invalid (blank).
- Reset mid-frame: the next cycle restarts at (0,0) with a blanked pipeline. The first valid pixel appears 3 cycles after `rst` deasserts.
- Wrap conditions: `hcnt` 799→0 increments `vcnt`; `vcnt` 524→0 increments the blink counter. When both wrap in the same cycle, all three updates occur in that cycle.

## Structure
- Package `vga_text_pkg` holds:
  - H/V visible, porch, sync and total constants.
  - Cell width 12, height 16, 53 columns, 30 rows, 64-column text stride.
- Sub-module `vga_timing` contains the raster counters, cell counters and raw sync/visible flags.
- `vga_text_render` contains the fetch pipeline, cursor and colour logic.

## Test plan
- Reset: assert `rst` 5 cycles. Required: `vga_hs`=`vga_vs`=1, `vga_de`=0, RGB=0, `text_addr`=0. After release, the first `vga_de`=1 appears 3 cycles later.
- Line timing: `vga_hs` is low for output cycles 659..754 of each line with period 800. `vga_vs` is low for lines 490..491 and the frame is 420000 cycles.
- Glyph: text model returns 8'h41 at address 0; ROM model returns 12'hF0F at 12'h410. Required: `font_addr`=12'h410 in cycle 1. Line-0 output pixels 0..11 are FG×4, BG×4, FG×4.
- Cell stepping: `text_addr` changes 0→1 at `hcnt`=12 and reaches 52 at `hcnt`=624. At `vcnt`=16 it starts at 11'h040. Pixels 636..639 are BG with `vga_de`=1.
- Cursor, with `BLINK_FRAMES`=2, cursor (0,0) and all-zero glyphs: cell (0,0) is BG in frames 0–1, FG in frames 2–3, and BG again in frame 4. With `cursor_en`=0 it is always BG.
- Reset mid-line at `hcnt`=300: outputs go blank the next cycle and the raster restarts at (0,0) with correct sync timing.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared raster timing, character-cell geometry and pipeline stage types
// for the text-mode VGA pixel generator.
package vga_text_pkg;

    // 640x480@60 horizontal timing, in pixel clocks.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // 640x480@60 vertical timing, in lines.
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Character cell geometry and text buffer layout.
    localparam int CELL_W      = 12;
    localparam int CELL_H      = 16;
    localparam int TEXT_COLS   = 53;
    localparam int TEXT_ROWS   = 30;
    localparam int TEXT_STRIDE = 64;
    localparam int COL_W       = $clog2(TEXT_STRIDE);

    // Stage 1 carries everything needed to form the font address and
    // everything that must stay aligned with the pixel it belongs to.
    typedef struct packed {
        logic       valid;
        logic       de;
        logic       hs;
        logic       vs;
        logic       margin;
        logic       cursor;
        logic [3:0] px;
        logic [3:0] line;
    } stage1_t;

    // Stage 2 only needs what the bit select and colour mux consume.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       margin;
        logic       cursor;
        logic [3:0] px;
    } stage2_t;

    localparam stage1_t STAGE1_IDLE = '{valid: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1,
                                        margin: 1'b0, cursor: 1'b0, px: 4'd0, line: 4'd0};
    localparam stage2_t STAGE2_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1,
                                        margin: 1'b0, cursor: 1'b0, px: 4'd0};

    // Font rows are stored MSB-first: bit 11 is the leftmost pixel.
    function automatic logic [3:0] bit_index(input logic [3:0] px);
        return 4'(CELL_W - 1) - px;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus character-cell counters that step alongside them,
// so cell position never needs a divider. Also produces raw sync/visible.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] px,
    output logic [5:0] col,
    output logic [3:0] line,
    output logic [4:0] row,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       de_raw,
    output logic       frame_wrap
);

    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SW);
    localparam logic [3:0] PX_LAST    = 4'(CELL_W - 1);
    localparam logic [3:0] LINE_LAST  = 4'(CELL_H - 1);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       h_last;
    logic       v_last;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    // Advance pixel/line raster and the cell counters that shadow it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every counter updates from the
        // same pre-edge values regardless of statement order.
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            px   <= '0;
            col  <= '0;
            line <= '0;
            row  <= '0;
        end else begin
            if (h_last) begin
                hcnt <= '0;
                px   <= '0;
                col  <= '0;
            end else begin
                hcnt <= hcnt + 10'd1;
                if (px == PX_LAST) begin
                    px  <= '0;
                    col <= col + 6'd1;
                end else begin
                    px <= px + 4'd1;
                end
            end

            if (h_last) begin
                if (v_last) begin
                    vcnt <= '0;
                    line <= '0;
                    row  <= '0;
                end else begin
                    vcnt <= vcnt + 10'd1;
                    if (line == LINE_LAST) begin
                        line <= '0;
                        row  <= row + 5'd1;
                    end else begin
                        line <= line + 4'd1;
                    end
                end
            end
        end
    end

    assign hs_raw     = ~((hcnt >= HS_START) && (hcnt < HS_END));
    assign vs_raw     = ~((vcnt >= VS_START) && (vcnt < VS_END));
    assign de_raw     = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    assign frame_wrap = h_last && v_last;

endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel generator: fetches character codes and font rows through a
// 3-stage pipeline, applies the blinking cursor and drives aligned VGA pins.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 32,
    parameter int          H_VIS        = H_VISIBLE,
    parameter int          H_FP         = H_FRONT,
    parameter int          H_SW         = H_SYNC,
    parameter int          H_BP         = H_BACK,
    parameter int          V_VIS        = V_VISIBLE,
    parameter int          V_FP         = V_FRONT,
    parameter int          V_SW         = V_SYNC,
    parameter int          V_BP         = V_BACK
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] text_addr,
    input  logic [7:0]  char_code,
    output logic [11:0] font_addr,
    input  logic [11:0] font_row,
    input  logic [5:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_de
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [3:0]       px;
    logic [COL_W-1:0] col;
    logic [3:0]       line;
    logic [4:0]       row;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_raw;
    logic             frame_wrap;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               cursor_hit;
    logic               in_margin;
    stage1_t            s1;
    stage2_t            s2;
    logic               pixel_on;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .px        (px),
        .col       (col),
        .line      (line),
        .row       (row),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw),
        .de_raw    (de_raw),
        .frame_wrap(frame_wrap)
    );

    // Stage 0: text buffer address straight from the cell counters.
    assign text_addr  = {row, col};
    assign cursor_hit = cursor_en && (col == cursor_col) && (row == cursor_row) && blink_phase;
    assign in_margin  = (col >= COL_W'(TEXT_COLS)) || (row >= 5'(TEXT_ROWS));

    // Count completed frames; flip the cursor phase every BLINK_FRAMES of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Carry pixel attributes alongside the memory fetches (stages 1 and 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= STAGE1_IDLE;
            s2 <= STAGE2_IDLE;
        end else begin
            s1 <= '{valid: 1'b1, de: de_raw, hs: hs_raw, vs: vs_raw,
                    margin: in_margin, cursor: cursor_hit, px: px, line: line};
            s2 <= '{de: s1.de, hs: s1.hs, vs: s1.vs,
                    margin: s1.margin, cursor: s1.cursor, px: s1.px};
        end
    end

    // Stage 1: font ROM address; held at zero until the pipeline refills.
    always_comb begin
        // NOTE: default assigned first so no path leaves font_addr unassigned
        // and no latch is inferred.
        font_addr = '0;
        if (s1.valid) begin
            font_addr = {char_code, s1.line};
        end
    end

    // Stage 2: pick the glyph bit, invert under the cursor, force margin to BG.
    assign pixel_on = (font_row[bit_index(s2.px)] ^ s2.cursor) && !s2.margin;

    // Stage 3: registered pins; colour is blanked outside the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_de <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= s2.hs;
            vga_vs <= s2.vs;
            vga_de <= s2.de;
            if (!s2.de) begin
                {vga_r, vga_g, vga_b} <= 12'h000;
            end else if (pixel_on) begin
                {vga_r, vga_g, vga_b} <= FG_COLOR;
            end else begin
                {vga_r, vga_g, vga_b} <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render. A full-timing instance covers the
// horizontal path, glyph fetch and resets; a shortened-raster instance with
// BLINK_FRAMES=2 covers vertical sync and cursor blinking in few cycles.
module tb_vga_text_render;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Full-timing instance
    logic [10:0] text_addr;
    logic [7:0]  char_code;
    logic [11:0] font_addr;
    logic [11:0] font_row;
    logic [5:0]  cursor_col = 6'd0;
    logic [4:0]  cursor_row = 5'd0;
    logic        cursor_en  = 1'b0;
    logic        vga_hs, vga_vs, vga_de;
    logic [3:0]  vga_r, vga_g, vga_b;

    // Short-raster instance: 64 clocks x 40 lines, sync h 52..59, v 34..35
    logic [10:0] text_addr_s;
    logic [7:0]  char_code_s;
    logic [11:0] font_addr_s;
    logic [11:0] font_row_s;
    logic [5:0]  cursor_col_s = 6'd0;
    logic [4:0]  cursor_row_s = 5'd0;
    logic        cursor_en_s  = 1'b0;
    logic        vga_hs_s, vga_vs_s, vga_de_s;
    logic [3:0]  vga_r_s, vga_g_s, vga_b_s;

    localparam int SH_TOT = 64;
    localparam int SV_TOT = 40;
    localparam int SFRAME = SH_TOT * SV_TOT;

    int cyc;
    int n_cmp = 0;
    int n_err = 0;

    vga_text_render dut (
        .clk(clk), .rst(rst),
        .text_addr(text_addr), .char_code(char_code),
        .font_addr(font_addr), .font_row(font_row),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_de(vga_de)
    );

    vga_text_render #(
        .BLINK_FRAMES(2),
        .H_VIS(48), .H_FP(4), .H_SW(8), .H_BP(4),
        .V_VIS(32), .V_FP(2), .V_SW(2), .V_BP(4)
    ) dut_s (
        .clk(clk), .rst(rst),
        .text_addr(text_addr_s), .char_code(char_code_s),
        .font_addr(font_addr_s), .font_row(font_row_s),
        .cursor_col(cursor_col_s), .cursor_row(cursor_row_s), .cursor_en(cursor_en_s),
        .vga_hs(vga_hs_s), .vga_vs(vga_vs_s),
        .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s), .vga_de(vga_de_s)
    );

    function automatic logic [7:0] text_char(input logic [10:0] a);
        case (a)
            11'd0:         return 8'h41;
            11'd1:         return 8'h42;
            11'd52, 11'd53: return 8'h41;
            default:       return 8'h00;
        endcase
    endfunction

    function automatic logic [11:0] rom_row(input logic [11:0] a);
        case (a)
            12'h410: return 12'hF0F;
            12'h411: return 12'h0F0;
            12'h420: return 12'hC00;
            default: return 12'h000;
        endcase
    endfunction

    // Synchronous-read memory models (1-cycle latency)
    always @(posedge clk) begin
        char_code   <= text_char(text_addr);
        font_row    <= rom_row(font_addr);
        char_code_s <= 8'h00;
        font_row_s  <= 12'h000;
    end

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (vga_hs !== 1'b1) begin n_err++; $display("FAIL reset_hs got %b want 1", vga_hs); end
        n_cmp++; if (vga_vs !== 1'b1) begin n_err++; $display("FAIL reset_vs got %b want 1", vga_vs); end
        n_cmp++; if (vga_de !== 1'b0) begin n_err++; $display("FAIL reset_de got %b want 0", vga_de); end
        n_cmp++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_err++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b}); end
        n_cmp++; if (text_addr !== 11'h000) begin n_err++; $display("FAIL reset_text_addr got %h want 000", text_addr); end
        n_cmp++; if (font_addr !== 12'h000) begin n_err++; $display("FAIL reset_font_addr got %h want 000", font_addr); end
        n_cmp++; if (vga_de_s !== 1'b0) begin n_err++; $display("FAIL reset_de_short got %b want 0", vga_de_s); end
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 3; c++) begin
            step_to(c);
            n_cmp++;
            if (vga_de !== (c == 3)) begin
                n_err++; $display("FAIL first_de cycle %0d got %b want %b", c, vga_de, (c == 3));
            end
            if (c == 1) begin
                n_cmp++;
                if (font_addr !== 12'h410) begin
                    n_err++; $display("FAIL first_font_addr got %h want 410", font_addr);
                end
            end
        end
    endtask

    task automatic test_glyph();
        logic [11:0] pat;
        logic [11:0] exp_rgb;
        do_reset();
        // Line 0: cell 0 is 'A' row F0F, cell 1 is 'B' row C00
        for (int i = 0; i < 24; i++) begin
            step_to(3 + i);
            pat = (i < 12) ? 12'hF0F : 12'hC00;
            exp_rgb = pat[11 - (i % 12)] ? 12'hFFF : 12'h000;
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_de !== 1'b1) begin
                n_err++; $display("FAIL glyph_l0 px %0d got rgb %h de %b want rgb %h de 1",
                                  i, {vga_r, vga_g, vga_b}, vga_de, exp_rgb);
            end
        end
        // Line 1 of 'A' is 0F0
        pat = 12'h0F0;
        for (int i = 0; i < 12; i++) begin
            step_to(800 + 3 + i);
            exp_rgb = pat[11 - i] ? 12'hFFF : 12'h000;
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
                n_err++; $display("FAIL glyph_l1 px %0d got %h want %h", i, {vga_r, vga_g, vga_b}, exp_rgb);
            end
        end
    endtask

    task automatic test_cell_stepping();
        logic [11:0] pat;
        logic [11:0] exp_rgb;
        logic        exp_de;
        do_reset();
        step_to(11);
        n_cmp++; if (text_addr !== 11'd0) begin n_err++; $display("FAIL addr_h11 got %h want 000", text_addr); end
        step_to(12);
        n_cmp++; if (text_addr !== 11'd1) begin n_err++; $display("FAIL addr_h12 got %h want 001", text_addr); end
        step_to(624);
        n_cmp++; if (text_addr !== 11'd52) begin n_err++; $display("FAIL addr_h624 got %h want 034", text_addr); end
        // Pixels 624..643: col 52 shows 'A', margin 636..639 BG, then blanking
        pat = 12'hF0F;
        for (int p = 624; p < 644; p++) begin
            step_to(p + 3);
            if (p < 636) exp_rgb = pat[11 - (p - 624)] ? 12'hFFF : 12'h000;
            else         exp_rgb = 12'h000;
            exp_de = (p < 640);
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_de !== exp_de) begin
                n_err++; $display("FAIL edge px %0d got rgb %h de %b want rgb %h de %b",
                                  p, {vga_r, vga_g, vga_b}, vga_de, exp_rgb, exp_de);
            end
        end
        step_to(15 * 800);
        n_cmp++; if (text_addr !== 11'h000) begin n_err++; $display("FAIL addr_v15 got %h want 000", text_addr); end
        step_to(16 * 800);
        n_cmp++; if (text_addr !== 11'h040) begin n_err++; $display("FAIL addr_v16 got %h want 040", text_addr); end
        step_to(16 * 800 + 12);
        n_cmp++; if (text_addr !== 11'h041) begin n_err++; $display("FAIL addr_v16_h12 got %h want 041", text_addr); end
    endtask

    task automatic test_hsync();
        int  h;
        logic exp_hs;
        logic exp_de;
        do_reset();
        for (int c = 0; c < 3 * 800 + 3; c++) begin
            step_to(c);
            h = (c - 3) % 800;
            exp_hs = (c < 3) ? 1'b1 : !(h >= 656 && h <= 751);
            exp_de = (c >= 3) && (h < 640);
            n_cmp++;
            if (vga_hs !== exp_hs || vga_de !== exp_de || vga_vs !== 1'b1) begin
                n_err++; $display("FAIL hsync cycle %0d got hs %b de %b vs %b want hs %b de %b vs 1",
                                  c, vga_hs, vga_de, vga_vs, exp_hs, exp_de);
            end
        end
    endtask

    task automatic test_vsync_short();
        int  h;
        int  v;
        logic exp_hs;
        logic exp_vs;
        logic exp_de;
        do_reset();
        for (int c = 0; c < 2 * SFRAME + 10; c++) begin
            step_to(c);
            h = (c - 3) % SH_TOT;
            v = ((c - 3) / SH_TOT) % SV_TOT;
            exp_hs = (c < 3) ? 1'b1 : !(h >= 52 && h <= 59);
            exp_vs = (c < 3) ? 1'b1 : !(v >= 34 && v <= 35);
            exp_de = (c >= 3) && (h < 48) && (v < 32);
            n_cmp++;
            if (vga_hs_s !== exp_hs || vga_vs_s !== exp_vs || vga_de_s !== exp_de) begin
                n_err++; $display("FAIL vsync cycle %0d got hs %b vs %b de %b want hs %b vs %b de %b",
                                  c, vga_hs_s, vga_vs_s, vga_de_s, exp_hs, exp_vs, exp_de);
            end
        end
    endtask

    task automatic test_cursor();
        logic [11:0] exp_rgb;
        cursor_en_s  = 1'b1;
        cursor_col_s = 6'd0;
        cursor_row_s = 5'd0;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            exp_rgb = (f == 2 || f == 3) ? 12'hFFF : 12'h000;
            step_to(f * SFRAME + 3);
            n_cmp++;
            if ({vga_r_s, vga_g_s, vga_b_s} !== exp_rgb) begin
                n_err++; $display("FAIL cursor_cell frame %0d got %h want %h", f, {vga_r_s, vga_g_s, vga_b_s}, exp_rgb);
            end
            step_to(f * SFRAME + 3 + 12);
            n_cmp++;
            if ({vga_r_s, vga_g_s, vga_b_s} !== 12'h000) begin
                n_err++; $display("FAIL cursor_neighbour frame %0d got %h want 000", f, {vga_r_s, vga_g_s, vga_b_s});
            end
            step_to(f * SFRAME + 15 * SH_TOT + 11 + 3);
            n_cmp++;
            if ({vga_r_s, vga_g_s, vga_b_s} !== exp_rgb) begin
                n_err++; $display("FAIL cursor_corner frame %0d got %h want %h", f, {vga_r_s, vga_g_s, vga_b_s}, exp_rgb);
            end
            step_to(f * SFRAME + 16 * SH_TOT + 3);
            n_cmp++;
            if ({vga_r_s, vga_g_s, vga_b_s} !== 12'h000) begin
                n_err++; $display("FAIL cursor_row1 frame %0d got %h want 000", f, {vga_r_s, vga_g_s, vga_b_s});
            end
        end

        // Disabled cursor stays BG even in the on phase; then move it live.
        cursor_en_s = 1'b0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            step_to(f * SFRAME + 3);
            n_cmp++;
            if ({vga_r_s, vga_g_s, vga_b_s} !== 12'h000) begin
                n_err++; $display("FAIL cursor_off frame %0d got %h want 000", f, {vga_r_s, vga_g_s, vga_b_s});
            end
        end
        cursor_en_s  = 1'b1;
        cursor_col_s = 6'd1;
        step_to(2 * SFRAME + 12 + 3);
        n_cmp++;
        if ({vga_r_s, vga_g_s, vga_b_s} !== 12'hFFF) begin
            n_err++; $display("FAIL cursor_moved got %h want fff", {vga_r_s, vga_g_s, vga_b_s});
        end
        step_to(2 * SFRAME + SH_TOT + 3);
        n_cmp++;
        if ({vga_r_s, vga_g_s, vga_b_s} !== 12'h000) begin
            n_err++; $display("FAIL cursor_old_cell got %h want 000", {vga_r_s, vga_g_s, vga_b_s});
        end
        cursor_en_s  = 1'b0;
        cursor_col_s = 6'd0;
    endtask

    task automatic test_mid_line_reset();
        do_reset();
        step_to(300);
        n_cmp++; if (vga_de !== 1'b1) begin n_err++; $display("FAIL pre_reset_de got %b want 1", vga_de); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (vga_de !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
            n_err++; $display("FAIL midreset_blank got de %b rgb %h hs %b vs %b want de 0 rgb 000 hs 1 vs 1",
                              vga_de, {vga_r, vga_g, vga_b}, vga_hs, vga_vs);
        end
        n_cmp++;
        if (text_addr !== 11'h000 || font_addr !== 12'h000) begin
            n_err++; $display("FAIL midreset_addr got text %h font %h want 000 000", text_addr, font_addr);
        end
        rst = 1'b0;
        cyc = 0;
        step_to(2);
        n_cmp++; if (vga_de !== 1'b0) begin n_err++; $display("FAIL midreset_c2_de got %b want 0", vga_de); end
        step_to(3);
        n_cmp++;
        if (vga_de !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'hFFF) begin
            n_err++; $display("FAIL midreset_first_px got de %b rgb %h want de 1 rgb fff", vga_de, {vga_r, vga_g, vga_b});
        end
        step_to(12);
        n_cmp++; if (text_addr !== 11'd1) begin n_err++; $display("FAIL midreset_addr_h12 got %h want 001", text_addr); end
        step_to(658);
        n_cmp++; if (vga_hs !== 1'b1) begin n_err++; $display("FAIL midreset_hs_658 got %b want 1", vga_hs); end
        step_to(659);
        n_cmp++; if (vga_hs !== 1'b0) begin n_err++; $display("FAIL midreset_hs_659 got %b want 0", vga_hs); end
        step_to(754);
        n_cmp++; if (vga_hs !== 1'b0) begin n_err++; $display("FAIL midreset_hs_754 got %b want 0", vga_hs); end
        step_to(755);
        n_cmp++; if (vga_hs !== 1'b1) begin n_err++; $display("FAIL midreset_hs_755 got %b want 1", vga_hs); end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_glyph();
        test_cell_stepping();
        test_hsync();
        test_vsync_short();
        test_cursor();
        test_mid_line_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
